robot_icon_pipe: RTL and testbench
==================================

ROBOT_ICON_PIPE -- requirements
Module: robot_icon_pipe

Interface
REQ-001 Parameter SCALING_FACTOR, default 6, screen pixels per world cell and icon side length; legal range 2..16.
REQ-002 Parameter MARGIN_X, default 128, horizontal screen offset of world column 0.
REQ-003 Parameter MARGIN_Y, default 0, vertical screen offset of world row 0.
REQ-004 Parameter BODY_COLOR, default 12'h0F0, 12-bit RGB of icon body.
REQ-005 Parameter HEAD_COLOR, default 12'hF0F, 12-bit RGB of orientation (head) pixels.
REQ-006 Parameter BLINK_FRAMES, default 30, frames per blink half-period; legal range 1..255.
REQ-007 clk  in  1  system clock; all logic on the rising edge.
REQ-008 reset_n  in  1  synchronous active-low reset.
REQ-009 frame_start  in  1  one-cycle pulse at the start of each video frame.
REQ-010 pix_valid  in  1  pixel_row and pixel_column are valid this cycle.
REQ-011 pixel_row  in  12  screen row of the current pixel.
REQ-012 pixel_column  in  12  screen column of the current pixel.
REQ-013 LocX_reg  in  8  robot world X.
REQ-014 LocY_reg  in  8  robot world Y.
REQ-015 BotInfo_reg  in  8  robot info; bits [2:0] are orientation 0..7 (0 = N, clockwise in 45-degree steps).
REQ-016 blink_en  in  1  enables head blinking.
REQ-017 icon_valid  out  1  icon and icon_opaque are valid.
REQ-018 icon  out  12  pixel color; 12'h000 when transparent.
REQ-019 icon_opaque  out  1  1 = pixel lies on the icon; 0 = transparent.

Function
REQ-020 Shadow registers for LocX, LocY and orientation SHALL load from LocX_reg, LocY_reg and BotInfo_reg[2:0] only on a cycle with frame_start=1, and SHALL hold for the rest of the frame.
REQ-021 A pixel presented in the same cycle as frame_start SHALL be evaluated with the pre-update shadow values.
REQ-022 Latency SHALL be exactly 2 cycles: icon_valid at cycle t+2 equals pix_valid at cycle t, with no stalls and one pixel accepted per cycle.
REQ-023 Cycles with pix_valid=0 SHALL produce icon_valid=0, icon=12'h000 and icon_opaque=0 two cycles later.
REQ-024 Offsets SHALL be dx = pixel_column - MARGIN_X - S*LocX and dy = pixel_row - MARGIN_Y - S*LocY, where S = SCALING_FACTOR.
REQ-025 Coordinate arithmetic SHALL use at least 13-bit unsigned values so that S*(Loc+1) = 4096 does not wrap.
REQ-026 A pixel SHALL be inside the icon iff 0 <= dx <= S-1 and 0 <= dy <= S-1.
REQ-027 pixel_column < MARGIN_X or pixel_row < MARGIN_Y SHALL be treated as outside; negative differences SHALL never wrap into the icon.
REQ-028 Mid set M SHALL be {S/2-1, S/2} for even S and {(S-1)/2} for odd S.
REQ-029 Head pixels per orientation SHALL be:
  0: dy=0, dx in M.
  1: dy=0, dx=S-1.
  2: dx=S-1, dy in M.
  3: dx=S-1, dy=S-1.
  4: dy=S-1, dx in M.
  5: dy=S-1, dx=0.
  6: dx=0, dy in M.
  7: dx=0, dy=0.
REQ-030 An inside head pixel SHALL output HEAD_COLOR, unless hidden by REQ-033, in which case it SHALL output BODY_COLOR.
REQ-031 Other inside pixels SHALL output BODY_COLOR; every inside pixel SHALL set icon_opaque=1.
REQ-032 Outside pixels SHALL output icon=12'h000 and icon_opaque=0.
REQ-033 Blink counter (8-bit) and phase bit:
  - While blink_en=1, the counter SHALL increment on each frame_start.
  - On reaching BLINK_FRAMES-1 and receiving the next frame_start, the counter SHALL wrap to 0 and toggle phase.
  - Head pixels SHALL be hidden when blink_en=1 and phase=1.
REQ-034 While blink_en=0, the counter and phase SHALL be held at 0.
REQ-035 When blink_en falls, the counter and phase SHALL be 0 on the next cycle.

Reset
REQ-036 reset_n=0 at a rising edge SHALL clear the shadow registers, blink counter, phase and both pipeline stages.
REQ-037 After a reset edge, icon_valid=0, icon=12'h000 and icon_opaque=0 SHALL hold until new valid pixels propagate.
REQ-038 Reset mid-stream SHALL discard in-flight pixels; no output may be derived from a pixel accepted before reset.

Verification (S=6, MARGIN_X=128, MARGIN_Y=0 unless noted)
REQ-039 Head pixel: Loc=(10,20), orient 0, frame_start, then pixel (row 120, col 190) -> 2 cycles later icon_valid=1, icon=F0F, opaque=1.
REQ-040 Body and edges, same setup:
  - (121,188) -> 0F0, opaque.
  - (125,193) -> 0F0, opaque.
  - (126,190) -> 000, transparent.
  - (120,100) -> 000, transparent (below margin).
REQ-041 Orientation 3, same Loc: (125,193) -> F0F; (120,190) -> 0F0.
REQ-042 Shadow hold: set LocX_reg=11 without frame_start -> (121,188) still 0F0; after a frame_start, (121,188) -> 000 and (121,194) -> 0F0.
REQ-043 Blink, BLINK_FRAMES=2, blink_en=1:
  - After 2 frame_starts, (120,190) -> 0F0.
  - After 4 frame_starts -> F0F.
  - Drop blink_en -> F0F immediately.
REQ-044 Reset mid-stream: continuous pix_valid with reset_n=0 for one cycle -> icon_valid=0 for the next 2 cycles; shadow reads Loc=(0,0); pixel (0,128) -> 0F0 without a frame_start.

Source files
------------

// File: rtl/robot_icon_pipe.sv
// Robot icon overlay pipeline.
// Draws an S x S robot icon at the screen position of the robot's world cell.
// The pixel that marks the robot's heading is drawn in a separate colour and
// can blink. Frame-coherent shadow copies of the robot state make sure the
// icon never tears mid-frame. Two register stages give a fixed 2-cycle latency.

module robot_icon_pipe #(
    parameter int          SCALING_FACTOR = 6,
    parameter int          MARGIN_X       = 128,
    parameter int          MARGIN_Y       = 0,
    parameter logic [11:0] BODY_COLOR     = 12'h0F0,
    parameter logic [11:0] HEAD_COLOR     = 12'hF0F,
    parameter int          BLINK_FRAMES   = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [11:0] pixel_row,
    input  logic [11:0] pixel_column,
    input  logic [7:0]  LocX_reg,
    input  logic [7:0]  LocY_reg,
    input  logic [7:0]  BotInfo_reg,
    input  logic        blink_en,
    output logic        icon_valid,
    output logic [11:0] icon,
    output logic        icon_opaque
);

    // 16-bit coordinate arithmetic: the icon's far edge can reach 4096 and the
    // margin is added on top, so 12 bits would wrap into the visible area.
    localparam int CW = 16;

    localparam logic [CW-1:0] SCALE_W  = CW'(SCALING_FACTOR);
    localparam logic [CW-1:0] MARGIN_XW = CW'(MARGIN_X);
    localparam logic [CW-1:0] MARGIN_YW = CW'(MARGIN_Y);

    // Offsets inside the icon never exceed 15, so 4 bits hold them.
    localparam logic [3:0] EDGE_LAST = 4'(SCALING_FACTOR - 1);

    // Middle pixel(s) of an edge: two for even sizes, one for odd sizes.
    localparam logic [3:0] MID_LO = (SCALING_FACTOR % 2 == 0) ? 4'(SCALING_FACTOR / 2 - 1)
                                                              : 4'((SCALING_FACTOR - 1) / 2);
    localparam logic [3:0] MID_HI = (SCALING_FACTOR % 2 == 0) ? 4'(SCALING_FACTOR / 2)
                                                              : 4'((SCALING_FACTOR - 1) / 2);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Frame-coherent robot state and blink timing
    // ------------------------------------------------------------------
    logic [7:0] loc_x_q;
    logic [7:0] loc_y_q;
    logic [2:0] orient_q;
    logic [7:0] blink_cnt_q;
    logic       blink_phase_q;
    logic       hide_head;

    // Upper BotInfo bits carry information this block does not draw.
    logic       botinfo_unused;
    assign botinfo_unused = ^BotInfo_reg[7:3];

    // Shadow copies of the robot position/heading, refreshed only at frame start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            loc_x_q  <= '0;
            loc_y_q  <= '0;
            orient_q <= '0;
        end else if (frame_start) begin
            loc_x_q  <= LocX_reg;
            loc_y_q  <= LocY_reg;
            orient_q <= BotInfo_reg[2:0];
        end
    end

    // Frame counter and phase toggling every BLINK_FRAMES frames while blinking is on.
    always_ff @(posedge clk) begin
        if (!reset_n || !blink_en) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 8'd1;
            end
        end
    end

    // Gating on the live blink_en makes the head reappear as soon as blinking stops.
    assign hide_head = blink_en & blink_phase_q;

    // ------------------------------------------------------------------
    // Stage 0: position test against the current shadow state
    // ------------------------------------------------------------------
    logic [CW-1:0] origin_x;
    logic [CW-1:0] origin_y;
    logic [CW-1:0] col_ext;
    logic [CW-1:0] row_ext;
    logic [CW-1:0] dx_full;
    logic [CW-1:0] dy_full;
    logic          inside_x;
    logic          inside_y;

    // Screen origin of the icon and the pixel's unsigned offset from it; the
    // explicit >= test keeps pixels left/above the icon from wrapping inside.
    always_comb begin
        origin_x = MARGIN_XW + SCALE_W * {8'd0, loc_x_q};
        origin_y = MARGIN_YW + SCALE_W * {8'd0, loc_y_q};
        col_ext  = {4'd0, pixel_column};
        row_ext  = {4'd0, pixel_row};
        dx_full  = col_ext - origin_x;
        dy_full  = row_ext - origin_y;
        inside_x = (col_ext >= origin_x) && (dx_full < SCALE_W);
        inside_y = (row_ext >= origin_y) && (dy_full < SCALE_W);
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic       s1_valid;
    logic       s1_inside;
    logic [3:0] s1_dx;
    logic [3:0] s1_dy;
    logic [2:0] s1_orient;
    logic       s1_hide;

    // Capture the geometric result together with the state it was judged against.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_inside <= 1'b0;
            s1_dx     <= '0;
            s1_dy     <= '0;
            s1_orient <= '0;
            s1_hide   <= 1'b0;
        end else begin
            s1_valid  <= pix_valid;
            s1_inside <= pix_valid & inside_x & inside_y;
            s1_dx     <= dx_full[3:0];
            s1_dy     <= dy_full[3:0];
            s1_orient <= orient_q;
            s1_hide   <= hide_head;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 -> 2: head pixel classification and colour
    // ------------------------------------------------------------------
    logic        mid_x;
    logic        mid_y;
    logic        is_head;
    logic [11:0] s1_color;

    // Pick the heading marker pixels for the captured orientation.
    always_comb begin
        mid_x   = (s1_dx == MID_LO) || (s1_dx == MID_HI);
        mid_y   = (s1_dy == MID_LO) || (s1_dy == MID_HI);
        is_head = 1'b0;
        case (s1_orient)
            3'd0: is_head = (s1_dy == 4'd0)      && mid_x;
            3'd1: is_head = (s1_dy == 4'd0)      && (s1_dx == EDGE_LAST);
            3'd2: is_head = (s1_dx == EDGE_LAST) && mid_y;
            3'd3: is_head = (s1_dx == EDGE_LAST) && (s1_dy == EDGE_LAST);
            3'd4: is_head = (s1_dy == EDGE_LAST) && mid_x;
            3'd5: is_head = (s1_dy == EDGE_LAST) && (s1_dx == 4'd0);
            3'd6: is_head = (s1_dx == 4'd0)      && mid_y;
            default: is_head = (s1_dx == 4'd0)   && (s1_dy == 4'd0);
        endcase

        s1_color = 12'h000;
        if (s1_inside) begin
            s1_color = (is_head && !s1_hide) ? HEAD_COLOR : BODY_COLOR;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 register (outputs)
    // ------------------------------------------------------------------

    // Register the final colour; transparent pixels are forced to black.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            icon_valid  <= 1'b0;
            icon        <= 12'h000;
            icon_opaque <= 1'b0;
        end else begin
            icon_valid  <= s1_valid;
            icon        <= s1_color;
            icon_opaque <= s1_inside;
        end
    end

endmodule

// File: tb/tb_robot_icon_pipe.sv
// Testbench for robot_icon_pipe: directed scenarios followed by random traffic,
// every output cycle checked against a screen-level reference model.

module tb_robot_icon_pipe;

    localparam int          S    = 6;
    localparam int          MX   = 128;
    localparam int          MY   = 0;
    localparam int          BF   = 2;
    localparam logic [11:0] BODY = 12'h0F0;
    localparam logic [11:0] HEAD = 12'hF0F;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [11:0] pixel_row = '0;
    logic [11:0] pixel_column = '0;
    logic [7:0]  LocX_reg = '0;
    logic [7:0]  LocY_reg = '0;
    logic [7:0]  BotInfo_reg = '0;
    logic        blink_en = 1'b0;
    logic        icon_valid;
    logic [11:0] icon;
    logic        icon_opaque;

    // Robot state to present on the next driven cycle.
    logic [7:0]  nx_lx = '0;
    logic [7:0]  nx_ly = '0;
    logic [7:0]  nx_info = '0;
    logic        nx_ben = 1'b0;

    // Reference model state: what is latched for the current frame.
    int m_lx = 0;
    int m_ly = 0;
    int m_or = 0;
    int m_frames = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          chk;
        logic        v;
        logic        op;
        logic [11:0] col;
        bit          lit;
        logic        lit_v;
        logic [11:0] lit_icon;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    // Free-running clock.
    always #5 clk = ~clk;

    robot_icon_pipe #(
        .SCALING_FACTOR(S),
        .MARGIN_X(MX),
        .MARGIN_Y(MY),
        .BODY_COLOR(BODY),
        .HEAD_COLOR(HEAD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .frame_start(frame_start),
        .pix_valid(pix_valid),
        .pixel_row(pixel_row),
        .pixel_column(pixel_column),
        .LocX_reg(LocX_reg),
        .LocY_reg(LocY_reg),
        .BotInfo_reg(BotInfo_reg),
        .blink_en(blink_en),
        .icon_valid(icon_valid),
        .icon(icon),
        .icon_opaque(icon_opaque)
    );

    // Screen-level model: returns {opaque, colour} for one pixel.
    function automatic logic [12:0] model_pixel(input int row, input int col, input int lx,
                                                input int ly, input int orient, input bit hide);
        int dx;
        int dy;
        bit mx_hit;
        bit my_hit;
        bit head;
        dx = col - MX - S * lx;
        dy = row - MY - S * ly;
        if (dx < 0 || dx > S - 1 || dy < 0 || dy > S - 1) return 13'h0000;
        if (S % 2 == 0) begin
            mx_hit = (dx == S / 2 - 1) || (dx == S / 2);
            my_hit = (dy == S / 2 - 1) || (dy == S / 2);
        end else begin
            mx_hit = (dx == (S - 1) / 2);
            my_hit = (dy == (S - 1) / 2);
        end
        case (orient)
            0: head = (dy == 0) && mx_hit;
            1: head = (dy == 0) && (dx == S - 1);
            2: head = (dx == S - 1) && my_hit;
            3: head = (dx == S - 1) && (dy == S - 1);
            4: head = (dy == S - 1) && mx_hit;
            5: head = (dy == S - 1) && (dx == 0);
            6: head = (dx == 0) && my_hit;
            default: head = (dx == 0) && (dy == 0);
        endcase
        return {1'b1, (head && !hide) ? HEAD : BODY};
    endfunction

    task automatic checkOutput(input exp_t e);
        logic lit_op;
        if (e.chk) begin
            checks++;
            assert ({icon_valid, icon_opaque, icon} === {e.v, e.op, e.col})
            else begin
                errors++;
                $error("[TB] FAIL %s: observed v=%b op=%b icon=%h expected v=%b op=%b icon=%h",
                       e.tag, icon_valid, icon_opaque, icon, e.v, e.op, e.col);
            end
        end
        if (e.lit) begin
            lit_op = e.lit_v && (e.lit_icon != 12'h000);
            checks++;
            assert ({icon_valid, icon_opaque, icon} === {e.lit_v, lit_op, e.lit_icon})
            else begin
                errors++;
                $error("[TB] FAIL %s: observed v=%b op=%b icon=%h expected v=%b op=%b icon=%h",
                       e.tag, icon_valid, icon_opaque, icon, e.lit_v, lit_op, e.lit_icon);
            end
        end
    endtask

    // One clock cycle: check the output due now, drive new inputs, predict their result.
    task automatic applyStimulus(input bit rst_n_i, input bit fs, input bit pv,
                                 input int row, input int col, input bit use_lit,
                                 input logic lit_v, input logic [11:0] lit_icon,
                                 input string tag);
        exp_t e;
        exp_t prev;
        logic [12:0] m;
        bit hide;
        @(negedge clk);
        checkOutput(exp_q.pop_front());

        reset_n      = rst_n_i;
        frame_start  = fs;
        pix_valid    = pv;
        pixel_row    = 12'(row);
        pixel_column = 12'(col);
        LocX_reg     = nx_lx;
        LocY_reg     = nx_ly;
        BotInfo_reg  = nx_info;
        blink_en     = nx_ben;

        hide = nx_ben && (((m_frames / BF) % 2) == 1);
        m = model_pixel(int'(pixel_row), int'(pixel_column), m_lx, m_ly, m_or, hide);

        e.chk      = 1'b1;
        e.v        = pv;
        e.op       = pv & m[12];
        e.col      = pv ? m[11:0] : 12'h000;
        e.lit      = use_lit;
        e.lit_v    = lit_v;
        e.lit_icon = lit_icon;
        e.tag      = tag;

        if (!rst_n_i) begin
            e.v   = 1'b0;
            e.op  = 1'b0;
            e.col = 12'h000;
            prev      = exp_q[0];
            prev.chk  = 1'b1;
            prev.v    = 1'b0;
            prev.op   = 1'b0;
            prev.col  = 12'h000;
            prev.lit  = 1'b0;
            exp_q[0]  = prev;
            m_lx = 0;
            m_ly = 0;
            m_or = 0;
            m_frames = 0;
        end else begin
            if (fs) begin
                m_lx = int'(nx_lx);
                m_ly = int'(nx_ly);
                m_or = int'(nx_info) % 8;
            end
            if (!nx_ben) m_frames = 0;
            else if (fs) m_frames++;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit fs, input bit pv, input int row, input int col);
        applyStimulus(1'b1, fs, pv, row, col, 1'b0, 1'b0, 12'h000, "model");
    endtask

    task automatic pix_lit(input int row, input int col, input logic [11:0] want, input string tag);
        applyStimulus(1'b1, 1'b0, 1'b1, row, col, 1'b1, 1'b1, want, tag);
    endtask

    initial begin
        exp_t blank;
        blank.chk = 1'b0; blank.v = 1'b0; blank.op = 1'b0; blank.col = '0;
        blank.lit = 1'b0; blank.lit_v = 1'b0; blank.lit_icon = '0; blank.tag = "startup";
        exp_q.push_back(blank);
        exp_q.push_back(blank);

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 12'h000, "reset_state");
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 12'h000, "reset_hold");
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("[TB] orientation 0 at (10,20)");
        nx_lx = 8'd10; nx_ly = 8'd20; nx_info = 8'h00;
        step(1, 0, 0, 0);
        pix_lit(120, 190, 12'hF0F, "head_o0");
        pix_lit(121, 188, 12'h0F0, "body_left_edge");
        pix_lit(125, 193, 12'h0F0, "body_far_corner");
        pix_lit(126, 190, 12'h000, "below_icon");
        pix_lit(120, 100, 12'h000, "left_of_margin");

        $display("[TB] orientation 3, pixel on the frame_start cycle");
        nx_info = 8'hA3;
        applyStimulus(1'b1, 1'b1, 1'b1, 120, 190, 1'b1, 1'b1, 12'hF0F, "fs_same_cycle");
        pix_lit(125, 193, 12'hF0F, "head_o3");
        pix_lit(120, 190, 12'h0F0, "old_head_o3");

        $display("[TB] shadow hold");
        nx_lx = 8'd11;
        pix_lit(121, 188, 12'h0F0, "shadow_hold");
        step(1, 0, 0, 0);
        pix_lit(121, 188, 12'h000, "shadow_moved_old");
        pix_lit(121, 194, 12'h0F0, "shadow_moved_new");

        $display("[TB] blink");
        nx_lx = 8'd10; nx_info = 8'h00; nx_ben = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        pix_lit(120, 190, 12'h0F0, "blink_hidden");
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        pix_lit(120, 190, 12'hF0F, "blink_shown");
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        pix_lit(120, 190, 12'h0F0, "blink_hidden_again");
        nx_ben = 1'b0;
        pix_lit(120, 190, 12'hF0F, "blink_drop");
        nx_ben = 1'b1;
        pix_lit(120, 190, 12'hF0F, "blink_restart");
        nx_ben = 1'b0;

        $display("[TB] reset mid-stream");
        step(0, 1, 120, 190);
        step(0, 1, 120, 190);
        step(0, 1, 120, 190);
        applyStimulus(1'b0, 1'b0, 1'b1, 120, 190, 1'b1, 1'b0, 12'h000, "reset_discard");
        step(0, 1, 120, 190);
        pix_lit(0, 128, 12'h0F0, "reset_loc0");
        step(0, 0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            bit fs;
            bit pv;
            bit rst_n_i;
            int row;
            int col;
            if ($urandom_range(0, 15) == 0)
                nx_lx = ($urandom_range(0, 5) == 0) ? 8'd255 : 8'($urandom_range(0, 30));
            if ($urandom_range(0, 15) == 0)
                nx_ly = ($urandom_range(0, 5) == 0) ? 8'd255 : 8'($urandom_range(0, 30));
            if ($urandom_range(0, 7) == 0) nx_info = 8'($urandom);
            if ($urandom_range(0, 63) == 0) nx_ben = ~nx_ben;
            fs      = ($urandom_range(0, 5) == 0);
            pv      = ($urandom_range(0, 3) != 0);
            rst_n_i = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) != 0) begin
                col = MX + S * m_lx + int'($urandom_range(0, S + 3)) - 2;
                row = MY + S * m_ly + int'($urandom_range(0, S + 3)) - 2;
            end else begin
                col = int'($urandom_range(0, 4095));
                row = int'($urandom_range(0, 4095));
            end
            applyStimulus(rst_n_i, fs, pv, row & 4095, col & 4095,
                          1'b0, 1'b0, 12'h000, "random");
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
